// File: rtl/nihilist_stream_cipher_if.sv
// nihilist_stream_cipher_if: key-load, input and output handshake bundle. Rev 1.0
`default_nettype none

interface nihilist_stream_cipher_if;
  logic       key_wr;
  logic [7:0] key_data;
  logic       key_clear;
  logic       key_err;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_err;

  modport master (
    output key_wr, key_data, key_clear, mode, in_valid, in_data, in_last, out_ready,
    input  key_err, in_ready, out_valid, out_data, out_last, out_err
  );

  modport slave (
    input  key_wr, key_data, key_clear, mode, in_valid, in_data, in_last, out_ready,
    output key_err, in_ready, out_valid, out_data, out_last, out_err
  );
endinterface

`default_nettype wire

// File: rtl/nihilist_stream_cipher.sv
// nihilist_stream_cipher: Polybius-square Nihilist stream cipher, one-cycle latency. Rev 1.0
// Optional decrypt path is built only when macro NIHILIST_DECRYPT_EN is defined.
`default_nettype none

module nihilist_stream_cipher #(
  parameter int KEY_MAX_LEN = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  nihilist_stream_cipher_if.slave   bus
);

  localparam int IDX_W = (KEY_MAX_LEN > 1) ? $clog2(KEY_MAX_LEN) : 1;
  localparam int LEN_W = $clog2(KEY_MAX_LEN + 1);

  typedef enum logic [0:0] {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } key_state_t;

  // Returns row*10+col for characters in the square, 0 for anything else.
  function automatic logic [7:0] char_code(input logic [7:0] ch);
    case (ch)
      "M": char_code = 8'd11;  "I": char_code = 8'd12;  "H": char_code = 8'd13;
      "A": char_code = 8'd14;  "B": char_code = 8'd15;
      "C": char_code = 8'd21;  "D": char_code = 8'd22;  "E": char_code = 8'd23;
      "F": char_code = 8'd24;  "G": char_code = 8'd25;
      "K": char_code = 8'd31;  "L": char_code = 8'd32;  "N": char_code = 8'd33;
      "O": char_code = 8'd34;  "P": char_code = 8'd35;
      "Q": char_code = 8'd41;  "R": char_code = 8'd42;  "S": char_code = 8'd43;
      "T": char_code = 8'd44;  "U": char_code = 8'd45;
      "V": char_code = 8'd51;  "W": char_code = 8'd52;  "X": char_code = 8'd53;
      "Y": char_code = 8'd54;  "Z": char_code = 8'd55;
      default: char_code = 8'd0;
    endcase
  endfunction

  key_state_t       state;
  key_state_t       state_nxt;
  logic [7:0]       key_mem [KEY_MAX_LEN];
  logic [LEN_W-1:0] key_len;
  logic [IDX_W-1:0] idx;
  logic             in_ready;
  logic             accept;
  logic [7:0]       wr_code;
  logic             key_wr_ok;
  logic             key_wr_rej;
  logic             idx_wrap;
  logic [7:0]       key_code;
  logic [7:0]       enc_code;
  logic [7:0]       res_data;
  logic             res_err;

  assign accept     = bus.in_valid && in_ready;
  assign wr_code    = char_code(bus.key_data);
  assign key_wr_ok  = bus.key_wr && !bus.key_clear && !accept && (idx == '0) &&
                      (wr_code != 8'd0) && (key_len != LEN_W'(KEY_MAX_LEN));
  assign key_wr_rej = bus.key_wr && !bus.key_clear && !key_wr_ok;
  assign idx_wrap   = (LEN_W'(idx) == (key_len - LEN_W'(1)));
  assign key_code   = key_mem[idx];
  assign enc_code   = char_code(bus.in_data);
  assign bus.in_ready = in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    if (bus.key_clear) begin
      state_nxt = ST_EMPTY;
    end else if (key_wr_ok) begin
      state_nxt = ST_LOADED;
    end
    if (state == ST_LOADED) begin
      in_ready = !bus.out_valid || bus.out_ready;
    end
  end

`ifdef NIHILIST_DECRYPT_EN
  function automatic logic [7:0] square_char(input logic [3:0] row, input logic [3:0] col);
    case ({row, col})
      8'h11: square_char = "M";  8'h12: square_char = "I";  8'h13: square_char = "H";
      8'h14: square_char = "A";  8'h15: square_char = "B";
      8'h21: square_char = "C";  8'h22: square_char = "D";  8'h23: square_char = "E";
      8'h24: square_char = "F";  8'h25: square_char = "G";
      8'h31: square_char = "K";  8'h32: square_char = "L";  8'h33: square_char = "N";
      8'h34: square_char = "O";  8'h35: square_char = "P";
      8'h41: square_char = "Q";  8'h42: square_char = "R";  8'h43: square_char = "S";
      8'h44: square_char = "T";  8'h45: square_char = "U";
      8'h51: square_char = "V";  8'h52: square_char = "W";  8'h53: square_char = "X";
      8'h54: square_char = "Y";  8'h55: square_char = "Z";
      default: square_char = 8'hFF;
    endcase
  endfunction

  logic [7:0] dec_diff;
  logic [7:0] dec_row;
  logic [7:0] dec_col;
  logic [7:0] dec_char;
  logic       dec_err;

  // Row is range-checked before truncation so that e.g. row 17 cannot alias row 1.
  always_comb begin
    dec_diff = bus.in_data - key_code;
    dec_row  = dec_diff / 8'd10;
    dec_col  = dec_diff % 8'd10;
    dec_char = square_char(dec_row[3:0], dec_col[3:0]);
    dec_err  = (bus.in_data < key_code) || (dec_row > 8'd5) || (dec_char == 8'hFF);
    if (bus.mode) begin
      res_err  = dec_err;
      res_data = dec_err ? 8'hFF : dec_char;
    end else begin
      res_err  = (enc_code == 8'd0);
      res_data = res_err ? 8'hFF : (enc_code + key_code);
    end
  end
`else
  always_comb begin
    res_err  = (enc_code == 8'd0);
    res_data = res_err ? 8'hFF : (enc_code + key_code);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (key_wr_ok) begin
      key_mem[key_len[IDX_W-1:0]] <= wr_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_len       <= '0;
      idx           <= '0;
      bus.key_err   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 8'd0;
      bus.out_last  <= 1'b0;
      bus.out_err   <= 1'b0;
    end else begin
      bus.key_err <= key_wr_rej;
      if (bus.key_clear) begin
        key_len <= '0;
        idx     <= '0;
      end else begin
        if (key_wr_ok) begin
          key_len <= key_len + LEN_W'(1);
        end
        if (accept) begin
          idx <= (bus.in_last || idx_wrap) ? '0 : idx + IDX_W'(1);
        end
      end
      // Output register is independent of key_clear so pending results survive it.
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= res_data;
        bus.out_last  <= bus.in_last;
        bus.out_err   <= res_err;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nihilist_stream_cipher.sv
// tb_nihilist_stream_cipher: directed-vector bench for nihilist_stream_cipher. Rev 1.0
`default_nettype none

module tb_nihilist_stream_cipher;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  nihilist_stream_cipher_if bus ();

  nihilist_stream_cipher #(.KEY_MAX_LEN(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic idle_inputs();
    bus.key_wr    = 1'b0;
    bus.key_data  = 8'd0;
    bus.key_clear = 1'b0;
    bus.mode      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic clear_key();
    bus.key_clear = 1'b1;
    @(posedge clk); #1;
    bus.key_clear = 1'b0;
  endtask

  task automatic load_key(input string s);
    for (int i = 0; i < s.len(); i++) begin
      bus.key_wr   = 1'b1;
      bus.key_data = s[i];
      @(posedge clk); #1;
    end
    bus.key_wr = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, input logic last, input logic m);
    bus.in_valid = 1'b1;
    bus.in_data  = c;
    bus.in_last  = last;
    bus.mode     = m;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.mode     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #12;
    total++;
    if ({bus.out_valid, bus.out_data, bus.out_last, bus.out_err, bus.key_err, bus.in_ready} !== 13'd0)
      $display("FAIL reset_outputs: got v=%b d=%0d l=%b e=%b kerr=%b rdy=%b required all 0",
               bus.out_valid, bus.out_data, bus.out_last, bus.out_err, bus.key_err, bus.in_ready);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.in_ready !== 1'b0)
      $display("FAIL reset_empty_ready: got %b required 0", bus.in_ready);
    else passed++;
  endtask

  task automatic test_encrypt_hello();
    string      msg = "HELLO";
    logic [7:0] exp [5] = '{8'd44, 8'd46, 8'd86, 8'd63, 8'd57};
    clear_key();
    load_key("KEY");
    for (int i = 0; i < 5; i++) begin
      send(msg[i], (i == 4), 1'b0);
      total++;
      if ({bus.out_valid, bus.out_data, bus.out_last, bus.out_err} !== {1'b1, exp[i], (i == 4), 1'b0})
        $display("FAIL hello_%0d: got v=%b d=%0d l=%b e=%b required v=1 d=%0d l=%b e=0",
                 i, bus.out_valid, bus.out_data, bus.out_last, bus.out_err, exp[i], (i == 4));
      else passed++;
    end
  endtask

  task automatic test_char_errors();
    send("J", 1'b0, 1'b0);
    total++;
    if ({bus.out_valid, bus.out_data, bus.out_err} !== {1'b1, 8'hFF, 1'b1})
      $display("FAIL err_J: got d=%h e=%b required d=ff e=1", bus.out_data, bus.out_err);
    else passed++;
    send("a", 1'b0, 1'b0);
    total++;
    if ({bus.out_valid, bus.out_data, bus.out_err} !== {1'b1, 8'hFF, 1'b1})
      $display("FAIL err_a: got d=%h e=%b required d=ff e=1", bus.out_data, bus.out_err);
    else passed++;
    send("H", 1'b1, 1'b0);
    total++;
    if ({bus.out_valid, bus.out_data, bus.out_last, bus.out_err} !== {1'b1, 8'd67, 1'b1, 1'b0})
      $display("FAIL err_next_H: got d=%0d l=%b e=%b required d=67 l=1 e=0",
               bus.out_data, bus.out_last, bus.out_err);
    else passed++;
  endtask

  task automatic test_backpressure();
    string      rest = "LLO";
    logic [7:0] exp [3] = '{8'd86, 8'd63, 8'd57};
    send("H", 1'b0, 1'b0);
    total++;
    if (bus.out_data !== 8'd44)
      $display("FAIL bp_first: got %0d required 44", bus.out_data);
    else passed++;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = "E";
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({bus.out_valid, bus.out_data, bus.in_ready} !== {1'b1, 8'd44, 1'b0})
        $display("FAIL bp_hold_%0d: got v=%b d=%0d rdy=%b required v=1 d=44 rdy=0",
                 i, bus.out_valid, bus.out_data, bus.in_ready);
      else passed++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'd46})
      $display("FAIL bp_release: got v=%b d=%0d required v=1 d=46", bus.out_valid, bus.out_data);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      send(rest[i], (i == 2), 1'b0);
      total++;
      if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, exp[i], (i == 2)})
        $display("FAIL bp_tail_%0d: got d=%0d l=%b required d=%0d l=%b",
                 i, bus.out_data, bus.out_last, exp[i], (i == 2));
      else passed++;
    end
  endtask

  task automatic test_key_errors();
    clear_key();
    load_key("J");
    total++;
    if (bus.key_err !== 1'b1)
      $display("FAIL key_invalid: got key_err=%b required 1", bus.key_err);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({bus.key_err, bus.in_ready} !== 2'b00)
      $display("FAIL key_invalid_after: got key_err=%b rdy=%b required 0 0", bus.key_err, bus.in_ready);
    else passed++;
    load_key("MIHABCDE");
    total++;
    if ({bus.key_err, bus.in_ready} !== 2'b01)
      $display("FAIL key_fill: got key_err=%b rdy=%b required 0 1", bus.key_err, bus.in_ready);
    else passed++;
    load_key("K");
    total++;
    if (bus.key_err !== 1'b1)
      $display("FAIL key_full: got key_err=%b required 1", bus.key_err);
    else passed++;
    send("M", 1'b0, 1'b0);
    total++;
    if (bus.out_data !== 8'd22)
      $display("FAIL key_mid_first: got %0d required 22", bus.out_data);
    else passed++;
    load_key("K");
    total++;
    if (bus.key_err !== 1'b1)
      $display("FAIL key_mid_msg: got key_err=%b required 1", bus.key_err);
    else passed++;
    send("M", 1'b1, 1'b0);
    total++;
    if ({bus.out_data, bus.key_err} !== {8'd23, 1'b0})
      $display("FAIL key_mid_second: got d=%0d key_err=%b required d=23 key_err=0",
               bus.out_data, bus.key_err);
    else passed++;
    bus.key_wr   = 1'b1;
    bus.key_data = "K";
    send("A", 1'b1, 1'b0);
    bus.key_wr = 1'b0;
    total++;
    if ({bus.out_data, bus.key_err} !== {8'd25, 1'b1})
      $display("FAIL key_during_xfer: got d=%0d key_err=%b required d=25 key_err=1",
               bus.out_data, bus.key_err);
    else passed++;
    bus.key_wr    = 1'b1;
    bus.key_data  = "K";
    bus.key_clear = 1'b1;
    @(posedge clk); #1;
    bus.key_wr    = 1'b0;
    bus.key_clear = 1'b0;
    total++;
    if ({bus.key_err, bus.in_ready} !== 2'b00)
      $display("FAIL key_clear_prio: got key_err=%b rdy=%b required 0 0", bus.key_err, bus.in_ready);
    else passed++;
  endtask

  task automatic test_reset_mid_message();
    load_key("KEY");
    send("H", 1'b0, 1'b0);
    send("E", 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    total++;
    if ({bus.out_valid, bus.out_data} !== 9'd0)
      $display("FAIL rst_async: got v=%b d=%0d required v=0 d=0", bus.out_valid, bus.out_data);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = "L";
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b00)
      $display("FAIL rst_no_key: got v=%b rdy=%b required 0 0", bus.out_valid, bus.in_ready);
    else passed++;
    bus.in_valid = 1'b0;
    load_key("KEY");
    send("H", 1'b1, 1'b0);
    total++;
    if (bus.out_data !== 8'd44)
      $display("FAIL rst_reload: got %0d required 44", bus.out_data);
    else passed++;
  endtask

`ifdef NIHILIST_DECRYPT_EN
  task automatic test_decrypt();
    logic [7:0] ct [5] = '{8'd44, 8'd46, 8'd86, 8'd63, 8'd57};
    string      pt = "HELLO";
    logic [7:0] pch;
    clear_key();
    load_key("KEY");
    for (int i = 0; i < 5; i++) begin
      pch = pt[i];
      send(ct[i], (i == 4), 1'b1);
      total++;
      if ({bus.out_data, bus.out_last, bus.out_err} !== {pch, (i == 4), 1'b0})
        $display("FAIL dec_%0d: got d=%h l=%b e=%b required d=%h l=%b e=0",
                 i, bus.out_data, bus.out_last, bus.out_err, pch, (i == 4));
      else passed++;
    end
    send(8'd31, 1'b1, 1'b1);
    total++;
    if ({bus.out_data, bus.out_err} !== {8'hFF, 1'b1})
      $display("FAIL dec_bad: got d=%h e=%b required d=ff e=1", bus.out_data, bus.out_err);
    else passed++;
  endtask
`else
  task automatic test_mode_ignored();
    send("H", 1'b1, 1'b1);
    total++;
    if ({bus.out_data, bus.out_err} !== {8'd44, 1'b0})
      $display("FAIL mode_ignored: got d=%0d e=%b required d=44 e=0", bus.out_data, bus.out_err);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_encrypt_hello();
    test_char_errors();
    test_backpressure();
    test_key_errors();
    test_reset_mid_message();
`ifdef NIHILIST_DECRYPT_EN
    test_decrypt();
`else
    test_mode_ignored();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
